// File: rtl/scan_pkg.sv
// Shared SCAN decoder definitions: opcodes, node-length rules and the
// bypass sequencer state type. Also used by the bypass mux and the
// write-back address generator.
package scan_pkg;

    localparam int OP_W  = 4;
    localparam int NV_W  = 11;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] TYPE1FUN  = 4'b0000;
    localparam logic [OP_W-1:0] TYPE2FUN  = 4'b0001;
    localparam logic [OP_W-1:0] BOTTOMFUN = 4'b0010;
    localparam logic [OP_W-1:0] TYPE3FUN  = 4'b0011;
    localparam logic [OP_W-1:0] NOP       = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // Beats a node of length nv occupies on the PE array. Illegal lengths
    // (including 0, the idle value) report a single beat so the terminal
    // count stays well defined.
    function automatic logic [CNT_W-1:0] beats(input logic [NV_W-1:0] nv);
        case (nv)
            11'd1024: beats = 4'd4;
            11'd512:  beats = 4'd2;
            default:  beats = 4'd1;
        endcase
    endfunction

    // Legal lengths are the powers of two from 2 up to 1024; in 11 bits
    // that is every power of two except 1.
    function automatic logic nv_legal(input logic [NV_W-1:0] nv);
        logic pow2;
        pow2     = (nv != 11'd0) && ((nv & (nv - 11'd1)) == 11'd0);
        nv_legal = pow2 && (nv != 11'd1);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Loadable beat counter: clears to zero, steps up to a terminal value and
// flags the last beat. Holds everything while hold_i is high.
module beat_counter
    import scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == term_i);

    // Next count: clear wins over step; never steps past the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (clear_i) begin
                cnt_d = '0;
            end else if (step_i && !last_o) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bypass_sched.sv
// Bypass path sequencer: accepts node operations, walks each through its
// beats and drives the opcode / length / PE-output history used by the
// bypass select logic.
//
// Handshake: op_ready is computed from state and stall only (never from
// op_valid); an operation transfers in any cycle where op_valid && op_ready.
// op_ready is high when idle or on the last beat of the running op, so
// back-to-back ops run with no bubble.
module bypass_sched
    import scan_pkg::*;
#(
    parameter int P = 256,
    parameter int Q = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [NV_W-1:0]     op_nv,
    input  logic                stall,
    input  logic [2*P*Q-1:0]    pe_o,
    output logic [OP_W-1:0]     opcode,
    output logic [OP_W-1:0]     opcode_delay,
    output logic [OP_W-1:0]     opcode_before,
    output logic [NV_W-1:0]     I_Nv,
    output logic [CNT_W-1:0]    channel_cnt,
    output logic [2*P*Q-1:0]    pe_o_before,
    output logic                op_done,
    output logic                op_err
);

    sched_state_e      state_q, state_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [OP_W-1:0]   opcode_delay_q;
    logic [OP_W-1:0]   opcode_before_q, opcode_before_d;
    logic [OP_W-1:0]   last_exec_q, last_exec_d;
    logic [NV_W-1:0]   nv_q, nv_d;
    logic [2*P*Q-1:0]  pe_o_before_q;
    logic              op_err_q, op_err_d;

    logic              accept;
    logic              acc_legal;
    logic              acc_illegal;
    logic              last_beat;
    logic              cnt_clear;
    logic              cnt_step;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  term;

    assign term = beats(nv_q) - 4'd1;

    beat_counter u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (stall),
        .clear_i (cnt_clear),
        .step_i  (cnt_step),
        .term_i  (term),
        .cnt_o   (cnt),
        .last_o  (last_beat)
    );

    assign op_ready    = !rst && !stall && ((state_q == ST_IDLE) || last_beat);
    assign accept      = op_valid && op_ready;
    assign acc_legal   = accept && nv_legal(op_nv);
    assign acc_illegal = accept && !nv_legal(op_nv);

    assign op_done       = !rst && !stall && (state_q == ST_RUN) && last_beat;
    assign op_err        = op_err_q && !rst;
    assign opcode        = opcode_q;
    assign opcode_delay  = opcode_delay_q;
    assign opcode_before = opcode_before_q;
    assign I_Nv          = nv_q;
    assign channel_cnt   = cnt;
    assign pe_o_before   = pe_o_before_q;

    // Next state: load on legal acceptance, otherwise step the running op
    // and drop to idle after its last beat. An illegal op is simply consumed.
    always_comb begin
        state_d         = state_q;
        opcode_d        = opcode_q;
        opcode_before_d = opcode_before_q;
        last_exec_d     = last_exec_q;
        nv_d            = nv_q;
        op_err_d        = acc_illegal;
        cnt_clear       = 1'b0;
        cnt_step        = 1'b0;
        if (!stall) begin
            if (acc_legal) begin
                state_d         = ST_RUN;
                opcode_d        = op_code;
                nv_d            = op_nv;
                // last_exec_q equals opcode_q while running, and remembers
                // the finished op while idle.
                opcode_before_d = last_exec_q;
                last_exec_d     = op_code;
                cnt_clear       = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (last_beat) begin
                    state_d   = ST_IDLE;
                    opcode_d  = NOP;
                    nv_d      = '0;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_step = 1'b1;
                end
            end
        end
    end

    // State and history registers; the one-cycle delay lines only advance
    // on non-stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            opcode_q        <= NOP;
            opcode_delay_q  <= NOP;
            opcode_before_q <= NOP;
            last_exec_q     <= NOP;
            nv_q            <= '0;
            pe_o_before_q   <= '0;
            op_err_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            opcode_before_q <= opcode_before_d;
            last_exec_q     <= last_exec_d;
            nv_q            <= nv_d;
            op_err_q        <= op_err_d;
            if (!stall) begin
                opcode_delay_q <= opcode_q;
                pe_o_before_q  <= pe_o;
            end
        end
    end

endmodule

// File: tb/tb_bypass_sched.sv
// Bench for bypass_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_bypass_sched;

    localparam int P    = 256;
    localparam int Q    = 6;
    localparam int PE_W = 2 * P * Q;
    localparam logic [3:0] NOP_C = 4'b1111;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic            op_valid;
    logic            op_ready;
    logic [3:0]      op_code;
    logic [10:0]     op_nv;
    logic            stall;
    logic [PE_W-1:0] pe_o;
    logic [3:0]      opcode;
    logic [3:0]      opcode_delay;
    logic [3:0]      opcode_before;
    logic [10:0]     I_Nv;
    logic [3:0]      channel_cnt;
    logic [PE_W-1:0] pe_o_before;
    logic            op_done;
    logic            op_err;

    always #5 clk = ~clk;

    bypass_sched #(.P(P), .Q(Q)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .op_nv         (op_nv),
        .stall         (stall),
        .pe_o          (pe_o),
        .opcode        (opcode),
        .opcode_delay  (opcode_delay),
        .opcode_before (opcode_before),
        .I_Nv          (I_Nv),
        .channel_cnt   (channel_cnt),
        .pe_o_before   (pe_o_before),
        .op_done       (op_done),
        .op_err        (op_err)
    );

    // ---------------- counters and compare helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] legal_tab [10] = '{11'd2, 11'd4, 11'd8, 11'd16, 11'd32,
                                    11'd64, 11'd128, 11'd256, 11'd512, 11'd1024};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [PE_W-1:0] act, input logic [PE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < PE_W / 32; i++) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s at %0t: word %0d got %h expected %h",
                             name, $time, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic bit m_legal(input logic [10:0] nv);
        bit ok;
        ok = 1'b0;
        foreach (legal_tab[i]) if (legal_tab[i] == nv) ok = 1'b1;
        return ok;
    endfunction

    function automatic int m_beats(input logic [10:0] nv);
        if (nv == 11'd1024) return 4;
        if (nv == 11'd512)  return 2;
        return 1;
    endfunction

    // ---------------- behavioural model + scoreboard ----------------
    // Model view: either idle, or executing one op at beat index m_idx of
    // m_beats(m_nv). Registered outputs follow directly from that view.
    bit              m_active = 1'b0;
    logic [3:0]      m_op     = NOP_C;
    logic [10:0]     m_nv     = '0;
    int              m_idx    = 0;
    logic [3:0]      m_last   = NOP_C;
    logic [3:0]      m_before = NOP_C;
    logic [3:0]      m_delay  = NOP_C;
    logic [PE_W-1:0] m_pe     = '0;
    bit              m_err    = 1'b0;
    logic [3:0]      exp_q[$];

    always @(negedge clk) begin
        bit   e_last, e_ready, e_done, e_err, acc;
        logic [3:0] front;
        e_last  = m_active && (m_idx == m_beats(m_nv) - 1);
        e_ready = !rst && !stall && (!m_active || e_last);
        e_done  = !rst && !stall && e_last;
        e_err   = !rst && m_err;

        chk("opcode",        32'(opcode),        32'(m_op));
        chk("opcode_delay",  32'(opcode_delay),  32'(m_delay));
        chk("opcode_before", 32'(opcode_before), 32'(m_before));
        chk("I_Nv",          32'(I_Nv),          32'(m_nv));
        chk("channel_cnt",   32'(channel_cnt),   32'(m_idx));
        chk("op_ready",      32'(op_ready),      32'(e_ready));
        chk("op_done",       32'(op_done),       32'(e_done));
        chk("op_err",        32'(op_err),        32'(e_err));
        chkw("pe_o_before",  pe_o_before,        m_pe);

        if (e_done) begin
            if (exp_q.size() == 0) begin
                chk("done_without_op", 32'(1), 32'(0));
            end else begin
                front = exp_q.pop_front();
                chk("done_opcode", 32'(opcode), 32'(front));
            end
        end

        // advance model to the next cycle
        acc = op_valid && e_ready;
        if (rst) begin
            m_active = 1'b0; m_op = NOP_C; m_nv = '0; m_idx = 0;
            m_last = NOP_C; m_before = NOP_C; m_delay = NOP_C;
            m_pe = '0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            m_err = acc && !m_legal(op_nv);
            if (!stall) begin
                m_delay = m_op;
                m_pe    = pe_o;
                if (acc && m_legal(op_nv)) begin
                    m_before = m_last;
                    m_last   = op_code;
                    m_op     = op_code;
                    m_nv     = op_nv;
                    m_idx    = 0;
                    m_active = 1'b1;
                    exp_q.push_back(op_code);
                end else if (m_active) begin
                    if (e_last) begin
                        m_active = 1'b0; m_op = NOP_C; m_nv = '0; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [3:0] c, input logic [10:0] n,
                         input bit s, input bit r);
        op_valid = v;
        op_code  = c;
        op_nv    = n;
        stall    = s;
        rst      = r;
        for (int i = 0; i < PE_W / 32; i++) pe_o[i*32 +: 32] = $urandom();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [PE_W-1:0] p1;

    initial begin
        // reset: two cycles, then first free cycle
        drive(0, 4'h0, 11'd0, 0, 1);
        chk("rst_opcode", 32'(opcode), 32'hF);
        chk("rst_ready",  32'(op_ready), 32'(0));
        chk("rst_done",   32'(op_done), 32'(0));
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 1);
        chk("rst_err", 32'(op_err), 32'(0));
        chk("rst_nv",  32'(I_Nv),   32'(0));
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("post_rst_ready",  32'(op_ready),      32'(1));
        chk("post_rst_delay",  32'(opcode_delay),  32'hF);
        chk("post_rst_before", 32'(opcode_before), 32'hF);
        chk("post_rst_cnt",    32'(channel_cnt),   32'(0));
        chkw("post_rst_pe",    pe_o_before,        '0);
        next_cyc();

        // single 1024 op
        drive(1, 4'b0001, 11'd1024, 0, 0);
        chk("s_ready", 32'(op_ready), 32'(1));
        next_cyc();
        for (int t = 1; t <= 4; t++) begin
            drive(0, 4'h0, 11'd0, 0, 0);
            chk("s_cnt",    32'(channel_cnt), 32'(t - 1));
            chk("s_opcode", 32'(opcode),      32'h1);
            chk("s_nv",     32'(I_Nv),        32'd1024);
            chk("s_done",   32'(op_done),     32'(t == 4));
            next_cyc();
        end
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("s_idle_opcode", 32'(opcode),       32'hF);
        chk("s_idle_delay",  32'(opcode_delay), 32'h1);
        next_cyc();

        // back-to-back: 512 then 16
        drive(1, 4'b0000, 11'd512, 0, 0);
        next_cyc();
        drive(1, 4'b0001, 11'd16, 0, 0);
        chk("b_ready_t1", 32'(op_ready), 32'(0));
        next_cyc();
        drive(1, 4'b0001, 11'd16, 0, 0);
        chk("b_ready_t2", 32'(op_ready), 32'(1));
        chk("b_done_t2",  32'(op_done),  32'(1));
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("b_opcode", 32'(opcode),        32'h1);
        chk("b_before", 32'(opcode_before), 32'h0);
        chk("b_nv",     32'(I_Nv),          32'd16);
        chk("b_done",   32'(op_done),       32'(1));
        next_cyc();

        // stall mid-op: 1024 op, stall t=2..4
        drive(1, 4'b0011, 11'd1024, 0, 0);
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        p1 = pe_o;
        next_cyc();
        for (int t = 2; t <= 7; t++) begin
            drive(0, 4'h0, 11'd0, (t >= 2 && t <= 4), 0);
            if (t <= 5) begin
                chk("st_cnt", 32'(channel_cnt), 32'(1));
                chkw("st_pe_frozen", pe_o_before, p1);
            end
            chk("st_done", 32'(op_done), 32'(t == 7));
            next_cyc();
        end

        // illegal nv
        drive(1, 4'b0000, 11'd300, 0, 0);
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("ill_err",    32'(op_err),   32'(1));
        chk("ill_opcode", 32'(opcode),   32'hF);
        chk("ill_ready",  32'(op_ready), 32'(1));
        next_cyc();
        drive(1, 4'b0001, 11'd4, 0, 0);
        chk("ill_err_gone", 32'(op_err), 32'(0));
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("ill_next_opcode", 32'(opcode),        32'h1);
        chk("ill_next_before", 32'(opcode_before), 32'h3);
        chk("ill_next_done",   32'(op_done),       32'(1));
        next_cyc();

        // reset mid-op at channel_cnt = 2
        drive(1, 4'b0000, 11'd1024, 0, 0);
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 1);
        chk("rm_cnt",  32'(channel_cnt), 32'(2));
        chk("rm_done", 32'(op_done),     32'(0));
        next_cyc();
        drive(0, 4'h0, 11'd0, 0, 0);
        chk("rm_opcode", 32'(opcode),        32'hF);
        chk("rm_before", 32'(opcode_before), 32'hF);
        chk("rm_cnt0",   32'(channel_cnt),   32'(0));
        chk("rm_done0",  32'(op_done),       32'(0));
        next_cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [10:0] n;
            logic [3:0]  c;
            c = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) n = 11'($urandom_range(0, 2047));
            else                           n = legal_tab[$urandom_range(0, 9)];
            drive($urandom_range(0, 3) != 0, c, n,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
            next_cyc();
        end

        // drain
        for (int i = 0; i < 6; i++) begin
            drive(0, 4'h0, 11'd0, 0, 0);
            next_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
